multicycle_seq: RTL

Multicycle instruction sequencer for the 32-bit single-issue core. It fetches an instruction word over a req/ack handshake and decodes its fields. It then steps the shared ALU, operand/writeback muxes, register file and data memory through FETCH/DECODE/EXEC/MEM/WB, and owns the program counter. It replaces purely combinational control with a cycle-accurate FSM that drives the same datapath selects and write enables.

---
 rtl/multicycle_seq.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_seq.sv
//------------------------------------------------------------------------------
// multicycle_seq
//
// Multicycle instruction sequencer for the 32-bit single-issue core. It fetches
// an instruction word over a req/ack handshake and latches it into IR. It then
// steps the shared ALU, operand/writeback muxes, register file and data memory
// through FETCH/DECODE/EXEC/MEM/WB. It also owns the program counter.
//
// Optional feature macro: INSTR_COUNT_EN
//    defined   -> o_retired_cnt counts retired instructions (wraps at 2^32)
//    undefined -> no counter logic, o_retired_cnt tied to 0
//
// Ports
//    i_clk          rising-edge clock
//    i_rst_n        asynchronous active-low reset
//    i_start        begin execution from pc=0 (sampled only in IDLE)
//    o_imem_req     instruction fetch request
//    o_imem_addr    instruction address (= pc)
//    i_imem_ack     instruction word valid on i_instr this cycle
//    i_instr        instruction word
//    o_dmem_req     data memory access request
//    i_dmem_ack     data access complete
//    o_rs/o_rd/o_rt register fields from IR (rt is 0 for I-type)
//    o_imm          sign-extended immediate
//    o_alu_op_sel   ALU function (funct field)
//    o_mux_sel1     ALU B source: 0=rt register, 1=imm
//    o_mux_sel2     writeback source: 0=ALU, 1=data memory
//    o_we1          register file write enable (registered)
//    o_we2          data memory write enable (registered)
//    o_busy         high in any state except IDLE and HALT
//    o_halted       high in HALT
//    o_retired_cnt  retired-instruction count
//
// State table
//    state    | meaning
//    IDLE     | waiting for i_start, pc held at 0
//    FETCH    | o_imem_req high until i_imem_ack, IR loaded on ack
//    DECODE   | one cycle, IR fields and selects valid
//    EXEC     | one cycle, dispatch on instruction class
//    MEM      | o_dmem_req high until i_dmem_ack (o_we2 held for STORE)
//    WB       | o_we1 high for one cycle, pc advances
//    HALT     | terminal, only i_rst_n leaves it
//------------------------------------------------------------------------------
module multicycle_seq #(
   parameter int ADDR_W = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   output logic              o_imem_req,
   output logic [ADDR_W-1:0] o_imem_addr,
   input  logic              i_imem_ack,
   input  logic [31:0]       i_instr,
   output logic              o_dmem_req,
   input  logic              i_dmem_ack,
   output logic [5:0]        o_rs,
   output logic [5:0]        o_rd,
   output logic [5:0]        o_rt,
   output logic [31:0]       o_imm,
   output logic [3:0]        o_alu_op_sel,
   output logic              o_mux_sel1,
   output logic              o_mux_sel2,
   output logic              o_we1,
   output logic              o_we2,
   output logic              o_busy,
   output logic              o_halted,
   output logic [31:0]       o_retired_cnt
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   localparam logic [3:0] FUNCT_HALT  = 4'hF;
   localparam logic [3:0] FUNCT_LOAD  = 4'hD;
   localparam logic [3:0] FUNCT_STORE = 4'hE;

   state_t            r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [31:0]       r_ir;
   logic              r_imem_req;
   logic              r_dmem_req;
   logic              r_we1;
   logic              r_we2;
   logic              r_busy;
   logic              r_halted;

   // Decode works purely from IR so the datapath never sees a live,
   // possibly changing, instruction bus.
   logic       w_itype;
   logic [3:0] w_funct;
   logic       w_is_halt;
   logic       w_is_load;
   logic       w_is_store;

   assign w_itype    = r_ir[0];
   assign w_funct    = r_ir[16:13];
   assign w_is_halt  = !w_itype && (w_funct == FUNCT_HALT);
   assign w_is_load  =  w_itype && (w_funct == FUNCT_LOAD);
   assign w_is_store =  w_itype && (w_funct == FUNCT_STORE);

   assign o_rs         = r_ir[6:1];
   assign o_rd         = r_ir[12:7];
   assign o_rt         = w_itype ? 6'd0 : r_ir[22:17];
   assign o_imm        = w_itype ? {{17{r_ir[31]}}, r_ir[31:17]}
                                 : {{23{r_ir[31]}}, r_ir[31:23]};
   assign o_alu_op_sel = w_funct;
   assign o_mux_sel1   = w_itype;
   assign o_mux_sel2   = w_is_load;

   assign o_imem_req  = r_imem_req;
   assign o_imem_addr = r_pc;
   assign o_dmem_req  = r_dmem_req;
   assign o_we1       = r_we1;
   assign o_we2       = r_we2;
   assign o_busy      = r_busy;
   assign o_halted    = r_halted;

   // All handshake and write-enable outputs are set on the transition into
   // the state that owns them, so they are flop outputs aligned with r_state.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_pc       <= '0;
         r_ir       <= '0;
         r_imem_req <= 1'b0;
         r_dmem_req <= 1'b0;
         r_we1      <= 1'b0;
         r_we2      <= 1'b0;
         r_busy     <= 1'b0;
         r_halted   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_state    <= S_FETCH;
                  r_pc       <= '0;
                  r_imem_req <= 1'b1;
                  r_busy     <= 1'b1;
               end
            end

            S_FETCH: begin
               if (i_imem_ack) begin
                  r_ir       <= i_instr;
                  r_imem_req <= 1'b0;
                  r_state    <= S_DECODE;
               end
            end

            S_DECODE: begin
               r_state <= S_EXEC;
            end

            S_EXEC: begin
               if (w_is_halt) begin
                  r_state  <= S_HALT;
                  r_busy   <= 1'b0;
                  r_halted <= 1'b1;
               end else if (w_is_load || w_is_store) begin
                  r_state    <= S_MEM;
                  r_dmem_req <= 1'b1;
                  r_we2      <= w_is_store;
               end else begin
                  r_state <= S_WB;
                  r_we1   <= 1'b1;
               end
            end

            S_MEM: begin
               if (i_dmem_ack) begin
                  r_dmem_req <= 1'b0;
                  r_we2      <= 1'b0;
                  if (w_is_store) begin
                     // STORE retires straight from MEM, no writeback cycle.
                     r_state    <= S_FETCH;
                     r_pc       <= r_pc + 1'b1;
                     r_imem_req <= 1'b1;
                  end else begin
                     r_state <= S_WB;
                     r_we1   <= 1'b1;
                  end
               end
            end

            S_WB: begin
               r_we1      <= 1'b0;
               r_pc       <= r_pc + 1'b1;
               r_state    <= S_FETCH;
               r_imem_req <= 1'b1;
            end

            S_HALT: begin
               r_state <= S_HALT;
            end

            default: begin
               r_state    <= S_IDLE;
               r_imem_req <= 1'b0;
               r_dmem_req <= 1'b0;
               r_we1      <= 1'b0;
               r_we2      <= 1'b0;
               r_busy     <= 1'b0;
               r_halted   <= 1'b0;
            end
         endcase
      end
   end

`ifdef INSTR_COUNT_EN
   logic        w_retire;
   logic [31:0] r_retired_cnt;

   // Retirement points: leaving WB, STORE completing in MEM, entering HALT.
   assign w_retire = (r_state == S_WB)
                  || ((r_state == S_MEM) && w_is_store && i_dmem_ack)
                  || ((r_state == S_EXEC) && w_is_halt);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_retired_cnt <= '0;
      end else if (w_retire) begin
         r_retired_cnt <= r_retired_cnt + 32'd1;
      end
   end

   assign o_retired_cnt = r_retired_cnt;
`else
   assign o_retired_cnt = '0;
`endif

endmodule
